seg7_scan_mux: RTL and testbench

- Consumer end of the parallel 7-segment bus produced by seg7_driver. Takes the full DISPLAY_COUNT x 8 segment image and time-multiplexes it onto one shared segment bus plus one anode select per display, as the physical board wiring requires.
- Snapshots the image once per frame so a position change from led never tears mid-scan.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg7_scan_if.sv | 33 +++
 rtl/seg7_scan_mux.sv | 137 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Segment-image bus between the display producer and the scan multiplexer.
// The producer drives enable and the image; the mux drives the scanned board lines.
interface seg7_scan_if #(
    parameter int DISPLAY_COUNT = 6,
    parameter int SEG_WIDTH     = 8
);
    localparam int DIGIT_W = (DISPLAY_COUNT > 1) ? $clog2(DISPLAY_COUNT) : 1;

    logic                                    enable_i;
    logic [DISPLAY_COUNT-1:0][SEG_WIDTH-1:0] seg7_i;
    logic [DISPLAY_COUNT-1:0]                anode_o;
    logic [SEG_WIDTH-1:0]                    seg_o;
    logic [DIGIT_W-1:0]                      digit_o;
    logic                                    frame_start_o;

    modport master (
        output enable_i,
        output seg7_i,
        input  anode_o,
        input  seg_o,
        input  digit_o,
        input  frame_start_o
    );

    modport slave (
        input  enable_i,
        input  seg7_i,
        output anode_o,
        output seg_o,
        output digit_o,
        output frame_start_o
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes a snapshotted DISPLAY_COUNT-digit segment image onto one shared
// segment bus with per-digit anode selects and an all-off gap before each digit.
module seg7_scan_mux #(
    parameter int DISPLAY_COUNT    = 6,
    parameter int SEG_WIDTH        = 8,
    parameter int DWELL_CYCLES     = 1000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    seg7_scan_if.slave bus
);
    localparam int DIGIT_W = (DISPLAY_COUNT > 1) ? $clog2(DISPLAY_COUNT) : 1;
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(DISPLAY_COUNT - 1);
    localparam logic               ANODE_OFF  = (ANODE_ACTIVE_LOW != 0);
    localparam logic               SEG_OFF    = (SEG_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Entry state for each digit slot: skip the gap when blanking is disabled.
    localparam state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_t                                  state_r, state_s;
    logic [CNT_W-1:0]                        cnt_r, cnt_s;
    logic [DIGIT_W-1:0]                      digit_r, digit_s;
    logic [DISPLAY_COUNT-1:0][SEG_WIDTH-1:0] frame_r, frame_s;
    logic                                    snap_s;
    logic                                    frame_start_r;
    logic [DISPLAY_COUNT-1:0]                anode_r, anode_s;
    logic [SEG_WIDTH-1:0]                    seg_r, seg_s;

    function automatic logic [SEG_WIDTH-1:0] seg_drive(input logic [SEG_WIDTH-1:0] lit);
        return lit ^ {SEG_WIDTH{SEG_OFF}};
    endfunction

    // Next-state, counter, digit and snapshot logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        digit_s = digit_r;
        frame_s = frame_r;
        snap_s  = 1'b0;
        if (!bus.enable_i) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            digit_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_s = bus.seg7_i;
                    snap_s  = 1'b1;
                    digit_s = '0;
                    cnt_s   = '0;
                    state_s = SLOT_ENTRY;
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        cnt_s   = '0;
                        state_s = ST_SHOW;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        cnt_s   = '0;
                        state_s = SLOT_ENTRY;
                        if (digit_r == LAST_DIGIT) begin
                            // Frame wrap: re-snapshot so the new image starts cleanly at digit 0.
                            digit_s = '0;
                            frame_s = bus.seg7_i;
                            snap_s  = 1'b1;
                        end else begin
                            digit_s = digit_r + DIGIT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    digit_s = '0;
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state so outputs stay registered.
    always_comb begin
        anode_s = {DISPLAY_COUNT{ANODE_OFF}};
        seg_s   = {SEG_WIDTH{SEG_OFF}};
        if (state_s == ST_SHOW) begin
            anode_s[digit_s] = ~ANODE_OFF;
            seg_s            = seg_drive(frame_s[digit_s]);
        end else begin
            anode_s = {DISPLAY_COUNT{ANODE_OFF}};
        end
    end

    // State, counter, frame buffer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            digit_r       <= '0;
            frame_r       <= '0;
            frame_start_r <= 1'b0;
            anode_r       <= {DISPLAY_COUNT{ANODE_OFF}};
            seg_r         <= {SEG_WIDTH{SEG_OFF}};
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            digit_r       <= digit_s;
            frame_r       <= frame_s;
            frame_start_r <= snap_s;
            anode_r       <= anode_s;
            seg_r         <= seg_s;
        end
    end

    assign bus.anode_o       = anode_r;
    assign bus.seg_o         = seg_r;
    assign bus.digit_o       = digit_r;
    assign bus.frame_start_o = frame_start_r;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed, table-driven bench for seg7_scan_mux: an active-low blanking build
// and a no-blank active-high build share one clock and reset.
module tb_seg7_scan_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   fs_count = 0;
    logic prev_fs = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_if #(.DISPLAY_COUNT(6), .SEG_WIDTH(8)) bus0 ();
    seg7_scan_if #(.DISPLAY_COUNT(6), .SEG_WIDTH(8)) bus1 ();

    seg7_scan_mux #(
        .DISPLAY_COUNT(6), .SEG_WIDTH(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));

    seg7_scan_mux #(
        .DISPLAY_COUNT(6), .SEG_WIDTH(8), .DWELL_CYCLES(4), .BLANK_CYCLES(0),
        .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
    ) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

    typedef struct {
        int         cyc;
        logic [7:0] d2_in;
        logic [5:0] anode;
        logic [7:0] seg;
        logic [2:0] digit;
        logic       fs;
    } vec_t;

    vec_t tbl[16];
    logic [7:0] s6[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [5:0] ea, input logic [7:0] es,
                        input logic [2:0] ed, input logic ef);
        chk({tag, " anode"}, 32'(bus0.anode_o), 32'(ea));
        chk({tag, " seg"}, 32'(bus0.seg_o), 32'(es));
        chk({tag, " digit"}, 32'(bus0.digit_o), 32'(ed));
        chk({tag, " frame_start"}, 32'(bus0.frame_start_o), 32'(ef));
    endtask

    // One clock, sampled on the falling edge, with the per-cycle invariants of dut0.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk($sformatf("onehot0 c%0d", cyc), 32'($countones(~bus0.anode_o) <= 1), 32'd1);
        chk($sformatf("fs_consec c%0d", cyc), 32'(prev_fs & bus0.frame_start_o), 32'd0);
        if (bus0.frame_start_o) fs_count++;
        prev_fs = bus0.frame_start_o;
    endtask

    initial begin
        tbl[0]  = '{1,  8'h04, 6'h3F, 8'hFF, 3'd0, 1'b1};
        tbl[1]  = '{2,  8'h04, 6'h3F, 8'hFF, 3'd0, 1'b0};
        tbl[2]  = '{3,  8'h04, 6'h3E, 8'hFE, 3'd0, 1'b0};
        tbl[3]  = '{6,  8'h04, 6'h3E, 8'hFE, 3'd0, 1'b0};
        tbl[4]  = '{7,  8'h04, 6'h3F, 8'hFF, 3'd1, 1'b0};
        tbl[5]  = '{8,  8'hFF, 6'h3F, 8'hFF, 3'd1, 1'b0};
        tbl[6]  = '{9,  8'hFF, 6'h3D, 8'hFD, 3'd1, 1'b0};
        tbl[7]  = '{15, 8'hFF, 6'h3B, 8'hFB, 3'd2, 1'b0};
        tbl[8]  = '{21, 8'hFF, 6'h37, 8'hF7, 3'd3, 1'b0};
        tbl[9]  = '{27, 8'hFF, 6'h2F, 8'hEF, 3'd4, 1'b0};
        tbl[10] = '{33, 8'hFF, 6'h1F, 8'hDF, 3'd5, 1'b0};
        tbl[11] = '{36, 8'hFF, 6'h1F, 8'hDF, 3'd5, 1'b0};
        tbl[12] = '{37, 8'hFF, 6'h3F, 8'hFF, 3'd0, 1'b1};
        tbl[13] = '{38, 8'hFF, 6'h3F, 8'hFF, 3'd0, 1'b0};
        tbl[14] = '{51, 8'hFF, 6'h3B, 8'h00, 3'd2, 1'b0};
        tbl[15] = '{73, 8'hFF, 6'h3F, 8'hFF, 3'd0, 1'b1};
        s6[0] = 8'hA5; s6[1] = 8'h5A; s6[2] = 8'h3C;
        s6[3] = 8'hC3; s6[4] = 8'h0F; s6[5] = 8'h81;

        bus0.enable_i = 1'b0;
        bus1.enable_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus0.seg7_i[k] = 8'h01 << k;
            bus1.seg7_i[k] = s6[k];
        end

        // Reset state, then one idle cycle with enable low.
        repeat (3) @(negedge clk);
        chk0("reset", 6'h3F, 8'hFF, 3'd0, 1'b0);
        chk("reset dut1 anode", 32'(bus1.anode_o), 32'h0);
        chk("reset dut1 seg", 32'(bus1.seg_o), 32'h0);
        rst_n = 1'b1;
        tick();
        chk0("idle", 6'h3F, 8'hFF, 3'd0, 1'b0);

        // Scan frames, with a mid-frame image change on digit 2.
        bus0.enable_i = 1'b1;
        cyc = 0;
        prev_fs = 1'b0;
        fs_count = 0;
        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) tick();
            chk0($sformatf("vec%0d c%0d", i, cyc), tbl[i].anode, tbl[i].seg, tbl[i].digit, tbl[i].fs);
            bus0.seg7_i[2] = tbl[i].d2_in;
        end
        while (cyc < 108) tick();
        chk("frame pulses in 3 frames", 32'(fs_count), 32'd3);

        // Drop enable during digit 3 SHOW of frame 4.
        while (cyc < 129) tick();
        chk0("d3 show", 6'h37, 8'hF7, 3'd3, 1'b0);
        bus0.enable_i = 1'b0;
        tick();
        chk0("disable", 6'h3F, 8'hFF, 3'd0, 1'b0);
        tick();
        chk0("idle hold", 6'h3F, 8'hFF, 3'd0, 1'b0);
        bus0.enable_i = 1'b1;
        tick();
        chk0("reenable c1", 6'h3F, 8'hFF, 3'd0, 1'b1);
        tick();
        tick();
        chk0("reenable c3", 6'h3E, 8'hFE, 3'd0, 1'b0);

        // Asynchronous reset between clock edges during SHOW.
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk0("async reset", 6'h3F, 8'hFF, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk0("restart c1", 6'h3F, 8'hFF, 3'd0, 1'b1);
        tick();
        tick();
        chk0("restart c3", 6'h3E, 8'hFE, 3'd0, 1'b0);

        // No-blank, active-high build: back-to-back digits, raw segments.
        bus1.enable_i = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            int d;
            tick();
            d = ((c - 1) / 4) % 6;
            chk($sformatf("nb onehot c%0d", c), 32'($countones(bus1.anode_o)), 32'd1);
            chk($sformatf("nb anode c%0d", c), 32'(bus1.anode_o), 32'(6'b000001 << d));
            chk($sformatf("nb seg c%0d", c), 32'(bus1.seg_o), 32'(s6[d]));
            chk($sformatf("nb digit c%0d", c), 32'(bus1.digit_o), 32'(d));
            chk($sformatf("nb fs c%0d", c), 32'(bus1.frame_start_o), 32'((c == 1) || (c == 25)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
